pram_port_arbiter: RTL and testbench

Two-requester arbiter for the single-port program/data RAM inside the MCU. It shares the port between the on-chip debugger (OCD) and the CPU load/store/fetch path, replacing the static read/write address mux at the top level. It adds a req/gnt handshake, tagged read-data return and an OCD lock for multi-word debug transfers.

---
 rtl/pram_port_arbiter_pkg.sv | 32 +++
 rtl/pram_read_tag_pipe.sv | 48 ++++
 rtl/pram_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_pram_port_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pram_port_arbiter_pkg.sv
// Shared definitions for the program-RAM port arbiter: owner encoding, tag format,
// lock states and the default read latency.
package pram_port_arbiter_pkg;

    localparam int unsigned MEM_ADDR_BITS         = 14;
    localparam int unsigned XLEN                  = 32;
    localparam int unsigned PRAM_READ_LATENCY_DEF = 1;

    typedef enum logic {
        PRAM_OWNER_OCD = 1'b0,
        PRAM_OWNER_CPU = 1'b1
    } pram_owner_e;

    typedef struct packed {
        logic        valid;
        pram_owner_e owner;
    } pram_tag_t;

    typedef enum logic {
        LOCK_OPEN = 1'b0,
        LOCK_HELD = 1'b1
    } pram_lock_state_e;

    // Round-robin choice on a conflict: whoever did not own the port last.
    function automatic pram_owner_e rr_winner(input pram_owner_e last_owner);
        if (last_owner == PRAM_OWNER_OCD) begin
            return PRAM_OWNER_CPU;
        end
        return PRAM_OWNER_OCD;
    endfunction

endpackage

// File: rtl/pram_read_tag_pipe.sv
// {valid, owner} delay line matching the RAM read latency; its last stage
// steers the shared read data to the OCD or the CPU.
module pram_read_tag_pipe
    import pram_port_arbiter_pkg::*;
#(
    parameter int unsigned READ_LATENCY = PRAM_READ_LATENCY_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  pram_owner_e in_owner,
    output logic        ocd_rvalid,
    output logic        cpu_rvalid
);

    pram_tag_t                    tag_in;
    pram_tag_t [READ_LATENCY-1:0] stage;

    always_comb begin
        tag_in       = '0;
        tag_in.valid = in_valid;
        tag_in.owner = in_owner;
    end

    if (READ_LATENCY == 1) begin : g_single
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                stage <= '0;
            end else begin
                stage[0] <= tag_in;
            end
        end
    end else begin : g_multi
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                stage <= '0;
            end else begin
                stage <= {stage[READ_LATENCY-2:0], tag_in};
            end
        end
    end

    always_comb begin
        ocd_rvalid = stage[READ_LATENCY-1].valid && (stage[READ_LATENCY-1].owner == PRAM_OWNER_OCD);
        cpu_rvalid = stage[READ_LATENCY-1].valid && (stage[READ_LATENCY-1].owner == PRAM_OWNER_CPU);
    end

endmodule

// File: rtl/pram_port_arbiter.sv
// OCD/CPU arbiter for the single-port program RAM with req/gnt, tagged read return and OCD lock.
// Define PRAM_ARB_OCD_PRIORITY_EN for strict OCD priority instead of round-robin.
module pram_port_arbiter
    import pram_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = MEM_ADDR_BITS,
    parameter int unsigned DATA_WIDTH   = XLEN,
    parameter int unsigned READ_LATENCY = PRAM_READ_LATENCY_DEF
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    ocd_req,
    input  logic                    ocd_we,
    input  logic [ADDR_WIDTH-1:0]   ocd_addr,
    input  logic [DATA_WIDTH-1:0]   ocd_wdata,
    input  logic                    ocd_lock,
    output logic                    ocd_gnt,
    output logic                    ocd_rvalid,

    input  logic                    cpu_req,
    input  logic                    cpu_we,
    input  logic [DATA_WIDTH/8-1:0] cpu_be,
    input  logic [ADDR_WIDTH-1:0]   cpu_addr,
    input  logic [DATA_WIDTH-1:0]   cpu_wdata,
    output logic                    cpu_gnt,
    output logic                    cpu_rvalid,
    output logic                    cpu_stalled,

    output logic                    mem_en,
    output logic                    mem_we,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    pram_lock_state_e lock_state;
    pram_lock_state_e lock_state_next;
    logic             cpu_blocked;
    logic             ocd_win;
    logic             cpu_win;
    pram_owner_e      grant_owner;
    logic             unused_rdata;

`ifndef PRAM_ARB_OCD_PRIORITY_EN
    pram_owner_e      last_owner;
`endif

    // Read data is consumed directly by the requesters; the arbiter never looks at it.
    assign unused_rdata = ^mem_rdata;

    // Lock FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_state <= LOCK_OPEN;
        end else begin
            lock_state <= lock_state_next;
        end
    end

    // Lock FSM: next state
    always_comb begin
        lock_state_next = lock_state;
        case (lock_state)
            LOCK_OPEN: if (ocd_win && ocd_lock) lock_state_next = LOCK_HELD;
            LOCK_HELD: if (!ocd_lock)           lock_state_next = LOCK_OPEN;
            default:                            lock_state_next = LOCK_OPEN;
        endcase
    end

    // Lock FSM: output. Releasing ocd_lock unblocks the CPU in that same cycle.
    always_comb begin
        cpu_blocked = (lock_state == LOCK_HELD) && ocd_lock;
    end

    always_comb begin
        ocd_win = 1'b0;
        cpu_win = 1'b0;
        if (!reset) begin
            if (cpu_blocked) begin
                ocd_win = ocd_req;
            end else if (ocd_req && cpu_req) begin
`ifdef PRAM_ARB_OCD_PRIORITY_EN
                ocd_win = 1'b1;
`else
                ocd_win = (rr_winner(last_owner) == PRAM_OWNER_OCD);
                cpu_win = (rr_winner(last_owner) == PRAM_OWNER_CPU);
`endif
            end else begin
                ocd_win = ocd_req;
                cpu_win = cpu_req;
            end
        end
    end

    assign ocd_gnt = ocd_win;
    assign cpu_gnt = cpu_win;

`ifndef PRAM_ARB_OCD_PRIORITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_owner <= PRAM_OWNER_OCD;
        end else if (ocd_win) begin
            last_owner <= PRAM_OWNER_OCD;
        end else if (cpu_win) begin
            last_owner <= PRAM_OWNER_CPU;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_stalled <= 1'b0;
        end else begin
            cpu_stalled <= cpu_req && !cpu_win;
        end
    end

    always_comb begin
        mem_en    = ocd_win || cpu_win;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (ocd_win) begin
            mem_we    = ocd_we;
            mem_be    = '1;
            mem_addr  = ocd_addr;
            mem_wdata = ocd_wdata;
        end else if (cpu_win) begin
            mem_we    = cpu_we;
            mem_be    = cpu_be;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end
    end

    always_comb begin
        grant_owner = PRAM_OWNER_OCD;
        if (cpu_win) begin
            grant_owner = PRAM_OWNER_CPU;
        end
    end

    pram_read_tag_pipe #(
        .READ_LATENCY (READ_LATENCY)
    ) u_read_tag_pipe (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (mem_en && !mem_we),
        .in_owner   (grant_owner),
        .ocd_rvalid (ocd_rvalid),
        .cpu_rvalid (cpu_rvalid)
    );

endmodule

// File: tb/tb_pram_port_arbiter.sv
// Randomized and directed bench for pram_port_arbiter against a transaction-level
// reference model with a behavioural RAM attached to the mem_* port.
module tb_pram_port_arbiter;

    localparam int unsigned AW    = 8;
    localparam int unsigned DW    = 32;
    localparam int unsigned RL    = 3;
    localparam int unsigned NWORD = 48;

    logic          clk = 1'b0;
    logic          reset;
    logic          ocd_req, ocd_we, ocd_lock, ocd_gnt, ocd_rvalid;
    logic [AW-1:0] ocd_addr;
    logic [DW-1:0] ocd_wdata;
    logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid, cpu_stalled;
    logic [3:0]    cpu_be;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          mem_en, mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    pram_port_arbiter #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .READ_LATENCY (RL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ocd_req     (ocd_req),
        .ocd_we      (ocd_we),
        .ocd_addr    (ocd_addr),
        .ocd_wdata   (ocd_wdata),
        .ocd_lock    (ocd_lock),
        .ocd_gnt     (ocd_gnt),
        .ocd_rvalid  (ocd_rvalid),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_be      (cpu_be),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_gnt     (cpu_gnt),
        .cpu_rvalid  (cpu_rvalid),
        .cpu_stalled (cpu_stalled),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_be      (mem_be),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM with RL cycles of read latency.
    logic [DW-1:0] ram     [256];
    logic [DW-1:0] rd_pipe [RL];

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end else begin
                rd_pipe[0] <= ram[mem_addr];
            end
        end
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[RL-1];

    // Reference model state
    typedef struct {
        int          due;
        bit          owner;
        logic [31:0] data;
    } rd_t;

    rd_t         exp_q [$];
    logic [31:0] m_mem [NWORD];
    bit          m_last;   // 0: OCD owned the port last, 1: CPU
    bit          m_lock;
    bit          m_stall;
    int          cyc;
    int          total;
    int          bad;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic set_reset(input logic v);
        reset = v;
        if (v) begin
            exp_q.delete();
            m_lock  = 1'b0;
            m_stall = 1'b0;
            m_last  = 1'b0;
        end
    endtask

    task automatic idle();
        ocd_req = 1'b0; ocd_we = 1'b0; ocd_lock = 1'b0; ocd_addr = '0; ocd_wdata = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_be = '0; cpu_addr = '0; cpu_wdata = '0;
    endtask

    // One clock: check DUT against the model at the falling edge, then advance the model.
    task automatic tick();
        bit          eo, ec, erv_o, erv_c;
        logic        ewe;
        logic [3:0]  ebe;
        logic [7:0]  eaddr;
        logic [31:0] ewd, edata;
        rd_t         e;
        @(negedge clk);
        eo = 1'b0;
        ec = 1'b0;
        if (!reset) begin
            if (m_lock && ocd_lock) begin
                eo = ocd_req;
            end else if (ocd_req && cpu_req) begin
`ifdef PRAM_ARB_OCD_PRIORITY_EN
                eo = 1'b1;
`else
                eo = m_last;
`endif
                ec = !eo;
            end else begin
                eo = ocd_req;
                ec = cpu_req;
            end
        end
        erv_o = 1'b0;
        erv_c = 1'b0;
        edata = '0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e     = exp_q.pop_front();
            edata = e.data;
            if (e.owner) erv_c = 1'b1;
            else         erv_o = 1'b1;
        end
        ewe   = eo ? ocd_we    : cpu_we;
        ebe   = eo ? 4'hF      : cpu_be;
        eaddr = eo ? ocd_addr  : cpu_addr;
        ewd   = eo ? ocd_wdata : cpu_wdata;

        check_eq("ocd_gnt",     32'(ocd_gnt),     32'(eo));
        check_eq("cpu_gnt",     32'(cpu_gnt),     32'(ec));
        check_eq("mem_en",      32'(mem_en),      32'(eo | ec));
        check_eq("cpu_stalled", 32'(cpu_stalled), 32'(m_stall));
        check_eq("ocd_rvalid",  32'(ocd_rvalid),  32'(erv_o));
        check_eq("cpu_rvalid",  32'(cpu_rvalid),  32'(erv_c));
        if (erv_o || erv_c) check_eq("mem_rdata", mem_rdata, edata);
        if (eo || ec) begin
            check_eq("mem_we",    32'(mem_we),   32'(ewe));
            check_eq("mem_be",    32'(mem_be),   32'(ebe));
            check_eq("mem_addr",  32'(mem_addr), 32'(eaddr));
            check_eq("mem_wdata", mem_wdata,     ewd);
        end
        if (reset) begin
            check_eq("rst_mem_bus", {mem_wdata[23:0], mem_addr}, 32'h0);
            check_eq("rst_mem_ctl", {28'h0, mem_we, mem_be[2:0]}, 32'h0);
        end

        if (!reset) begin
            if (eo || ec) begin
                if (ewe) begin
                    for (int b = 0; b < 4; b++) begin
                        if (ebe[b]) m_mem[eaddr][8*b +: 8] = ewd[8*b +: 8];
                    end
                end else begin
                    exp_q.push_back('{due: cyc + RL, owner: ec, data: m_mem[eaddr]});
                end
                m_last = ec;
            end
            m_lock  = ocd_lock && (m_lock || eo);
            m_stall = cpu_req && !ec;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        idle();
        set_reset(1'b1);
        tick();
        tick();
        set_reset(1'b0);

        // Preload every modelled word through OCD writes.
        for (int a = 0; a < NWORD; a++) begin
            ocd_req   = 1'b1;
            ocd_we    = 1'b1;
            ocd_addr  = 8'(a);
            ocd_wdata = (a == 16) ? 32'hDEADBEEF : (a == 32) ? 32'h11223344 : $urandom;
            tick();
        end
        idle();
        tick();

        // Lone OCD read of 0x10
        ocd_req  = 1'b1;
        ocd_addr = 8'h10;
        tick();
        idle();
        for (int i = 0; i < RL + 1; i++) tick();

        // Both requests held after reset: CPU, OCD, CPU, OCD
        set_reset(1'b1);
        tick();
        set_reset(1'b0);
        ocd_req  = 1'b1; ocd_addr = 8'h01;
        cpu_req  = 1'b1; cpu_addr = 8'h02;
        for (int i = 0; i < 4; i++) tick();
        idle();
        for (int i = 0; i < RL + 1; i++) tick();

        // CPU byte write to 0x20 then read back
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 4'b0010; cpu_addr = 8'h20; cpu_wdata = 32'h0000AB00;
        tick();
        cpu_we = 1'b0;
        tick();
        idle();
        for (int i = 0; i < RL + 1; i++) tick();
        check_eq("byte_write_ram", ram[8'h20], 32'h1122AB44);

        // OCD lock blocks the CPU until ocd_lock falls
        ocd_req = 1'b1; ocd_lock = 1'b1; ocd_addr = 8'h05;
        cpu_req = 1'b1; cpu_addr = 8'h06;
        tick();
        tick();
        ocd_req = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        ocd_lock = 1'b0;
        tick();
        idle();
        for (int i = 0; i < RL + 1; i++) tick();

        // Alternating OCD/CPU reads on consecutive cycles
        for (int i = 0; i < 6; i++) begin
            idle();
            if (i % 2 == 0) begin
                ocd_req = 1'b1; ocd_addr = 8'(10 + i);
            end else begin
                cpu_req = 1'b1; cpu_addr = 8'(10 + i);
            end
            tick();
        end
        idle();
        for (int i = 0; i < RL + 1; i++) tick();

        // Reset one cycle after a CPU read grant discards its return
        cpu_req = 1'b1; cpu_addr = 8'h07;
        tick();
        idle();
        set_reset(1'b1);
        tick();
        set_reset(1'b0);
        for (int i = 0; i < RL + 1; i++) tick();
        ocd_req = 1'b1; cpu_req = 1'b1; ocd_addr = 8'h08; cpu_addr = 8'h09;
        tick();
        idle();

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                set_reset(1'b1);
                tick();
                set_reset(1'b0);
            end
            ocd_req   = 1'($urandom_range(0, 1));
            ocd_we    = 1'($urandom_range(0, 1));
            ocd_addr  = 8'($urandom_range(0, NWORD - 1));
            ocd_wdata = $urandom;
            if ($urandom_range(0, 7) == 0) ocd_lock = 1'($urandom_range(0, 1));
            cpu_req   = 1'($urandom_range(0, 1));
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_be    = 4'($urandom_range(0, 15));
            cpu_addr  = 8'($urandom_range(0, NWORD - 1));
            cpu_wdata = $urandom;
            tick();
        end
        idle();
        for (int i = 0; i < RL + 2; i++) tick();
        check_eq("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
